uop_sequencer: RTL and testbench
================================

UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 SHALL have parameter MAX_UOP, default 6: highest legal micro-op index before a forced retire.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port RUN  input  1  level; 1 = execute instructions back to back.
REQ-005 SHALL have port STEP  input  1  single-cycle pulse; execute exactly one instruction from IDLE.
REQ-006 SHALL have port RESET_uOP  input  1  from controller_rom; current micro-op is the instruction's last.
REQ-007 SHALL have port READ_FLAGS  input  1  from controller_rom; latch ALU flags this cycle.
REQ-008 SHALL have ports ALU_ZERO, ALU_COUT  input  1 each  raw ALU flag outputs.
REQ-009 SHALL have port uOP  output  3  micro-op index to controller_rom.
REQ-010 SHALL have ports ZERO_FLAG, COUT_FLAG  output  1 each  registered flags to controller_rom.
REQ-011 SHALL have port INSTR_DONE  output  1  one-cycle pulse per retired instruction.
REQ-012 SHALL have port INSTR_COUNT  output  16  retired-instruction counter.
REQ-013 SHALL have port FAULT  output  1  sticky; micro-op overrun detected.

Function
REQ-014 SHALL implement states INIT, EXEC, IDLE; uOP = 3'b111 in INIT and IDLE (controller default/no-side-effect row).
REQ-015 INIT SHALL last exactly one cycle, then go to EXEC with uOP=0 if RUN=1, else IDLE.
REQ-016 IDLE SHALL go to EXEC with uOP=0 the cycle after RUN=1 is sampled.
REQ-017 In EXEC with uOP<2 (fetch/decode), RESET_uOP SHALL be ignored and uOP SHALL increment.
REQ-018 In EXEC with uOP>=2 and RESET_uOP=1: retire -- INSTR_DONE=1 next cycle, INSTR_COUNT+1 (wraps 16'hFFFF->0), uOP->0 if RUN=1 else state IDLE.
REQ-019 In EXEC with uOP>=2, RESET_uOP=0, uOP<MAX_UOP: uOP SHALL increment by 1.
REQ-020 In EXEC with uOP==MAX_UOP and RESET_uOP=0: FAULT SHALL set, uOP->0, INSTR_DONE and INSTR_COUNT unchanged.
REQ-021 RUN deassertion mid-instruction SHALL NOT abort it; halt takes effect only at retire.
REQ-022 Flags SHALL latch ZERO_FLAG<=ALU_ZERO, COUT_FLAG<=ALU_COUT on edges where READ_FLAGS=1 in EXEC; hold otherwise.
REQ-023 READ_FLAGS and RESET_uOP in the same cycle SHALL both take effect (flags latch and retire).
REQ-024 INSTR_DONE SHALL be low in every cycle not immediately following a retire.
REQ-025 FAULT SHALL clear only on RESET.

Reset
REQ-026 RESET=1 SHALL force, on that edge: state INIT, uOP=3'b111, ZERO_FLAG=0, COUT_FLAG=0, INSTR_DONE=0, INSTR_COUNT=0, FAULT=0, step pending cleared.
REQ-027 RESET SHALL override all other inputs, including mid-instruction and mid-step.

Configuration
REQ-028 Macro UOP_SINGLE_STEP_EN SHALL gate single-step support.
REQ-029 With UOP_SINGLE_STEP_EN defined: STEP=1 in IDLE SHALL enter EXEC uOP=0, run one instruction, and return to IDLE at its retire regardless of RUN; STEP outside IDLE ignored; RUN and STEP together in IDLE = RUN behaviour.
REQ-030 Without UOP_SINGLE_STEP_EN: STEP SHALL be ignored and no step-pending storage synthesised.

Verification
REQ-031 RESET high 2 cycles, RUN=1 -> uOP 7 (reset), 7 (INIT), then 0,1,2...; all other outputs 0.
REQ-032 RUN=1, RESET_uOP=1 at uOP=3 -> uOP sequence 0,1,2,3,0; INSTR_DONE pulses once; INSTR_COUNT=1.
REQ-033 RESET_uOP=1 at uOP=1 -> ignored, uOP goes to 2; RESET_uOP never asserted -> uOP 0..6 then 0, FAULT=1, INSTR_COUNT unchanged.
REQ-034 READ_FLAGS=1 with ALU_ZERO=1, ALU_COUT=0 at uOP=4 alongside RESET_uOP=1 -> ZERO_FLAG=1, COUT_FLAG=0 and retire in same edge; flags hold after.
REQ-035 RUN dropped at uOP=2, RESET_uOP at uOP=4 -> uOP 3,4 then 7 (IDLE); with UOP_SINGLE_STEP_EN, STEP pulse -> exactly one instruction, INSTR_COUNT+1, back to uOP=7.

Source files
------------

// File: rtl/uop_sequencer.sv
// uop_sequencer: walks the micro-op index of each instruction for the controller ROM,
// retires instructions on RESET_uOP, latches ALU flags, counts retired instructions
// and flags micro-op overruns.
// Optional feature: define UOP_SINGLE_STEP_EN to enable single-instruction stepping from IDLE.

module uop_sequencer #(
   parameter int MAX_UOP = 6
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        RUN,
   input  logic        STEP,
   input  logic        RESET_uOP,
   input  logic        READ_FLAGS,
   input  logic        ALU_ZERO,
   input  logic        ALU_COUT,
   output logic [2:0]  uOP,
   output logic        ZERO_FLAG,
   output logic        COUT_FLAG,
   output logic        INSTR_DONE,
   output logic [15:0] INSTR_COUNT,
   output logic        FAULT
);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      EXEC = 2'd1,
      IDLE = 2'd2
   } state_t;

   // Micro-op row 7 is the controller's side-effect-free default row.
   localparam logic [2:0] IdleUop  = 3'b111;
   localparam logic [2:0] MaxUop   = 3'(MAX_UOP);
   localparam logic [2:0] FirstExe = 3'd2;

   state_t      state_q, state_d;
   logic [2:0]  uop_q, uop_d;
   logic        zeroFlag_q, zeroFlag_d;
   logic        coutFlag_q, coutFlag_d;
   logic        instrDone_q, instrDone_d;
   logic [15:0] instrCount_q, instrCount_d;
   logic        fault_q, fault_d;

   logic        retire;
   logic        stepReq;
   logic        stepHold;

   // Fetch and decode rows (0 and 1) can never be an instruction's last micro-op.
   assign retire = (state_q == EXEC) && (uop_q >= FirstExe) && RESET_uOP;

`ifdef UOP_SINGLE_STEP_EN
   logic stepPending_q, stepPending_d;

   assign stepReq  = STEP;
   assign stepHold = stepPending_q;

   // A step armed from IDLE (without RUN) stays pending until its instruction retires.
   always_comb begin
      stepPending_d = stepPending_q;
      if ((state_q == IDLE) && !RUN && STEP) begin
         stepPending_d = 1'b1;
      end else if (retire) begin
         stepPending_d = 1'b0;
      end
   end

   // Step-pending register, cleared by reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stepPending_q <= 1'b0;
      end else begin
         stepPending_q <= stepPending_d;
      end
   end
`else
   logic unusedStep;

   assign unusedStep = STEP;
   assign stepReq    = 1'b0;
   assign stepHold   = 1'b0;
`endif

   // State and datapath registers; reset overrides every other input.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= INIT;
         uop_q        <= IdleUop;
         zeroFlag_q   <= 1'b0;
         coutFlag_q   <= 1'b0;
         instrDone_q  <= 1'b0;
         instrCount_q <= 16'd0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         uop_q        <= uop_d;
         zeroFlag_q   <= zeroFlag_d;
         coutFlag_q   <= coutFlag_d;
         instrDone_q  <= instrDone_d;
         instrCount_q <= instrCount_d;
         fault_q      <= fault_d;
      end
   end

   // Next-state logic: sequence micro-ops, retire, detect overrun, latch flags.
   always_comb begin
      state_d      = state_q;
      uop_d        = uop_q;
      zeroFlag_d   = zeroFlag_q;
      coutFlag_d   = coutFlag_q;
      instrDone_d  = 1'b0;
      instrCount_d = instrCount_q;
      fault_d      = fault_q;

      case (state_q)
         INIT: begin
            if (RUN) begin
               state_d = EXEC;
               uop_d   = 3'd0;
            end else begin
               state_d = IDLE;
               uop_d   = IdleUop;
            end
         end

         IDLE: begin
            if (RUN || stepReq) begin
               state_d = EXEC;
               uop_d   = 3'd0;
            end else begin
               uop_d   = IdleUop;
            end
         end

         EXEC: begin
            if (READ_FLAGS) begin
               zeroFlag_d = ALU_ZERO;
               coutFlag_d = ALU_COUT;
            end
            if (uop_q < FirstExe) begin
               uop_d = uop_q + 3'd1;
            end else if (RESET_uOP) begin
               instrDone_d  = 1'b1;
               instrCount_d = instrCount_q + 16'd1;
               if (RUN && !stepHold) begin
                  uop_d = 3'd0;
               end else begin
                  state_d = IDLE;
                  uop_d   = IdleUop;
               end
            end else if (uop_q >= MaxUop) begin
               fault_d = 1'b1;
               uop_d   = 3'd0;
            end else begin
               uop_d = uop_q + 3'd1;
            end
         end

         default: begin
            state_d = INIT;
            uop_d   = IdleUop;
         end
      endcase
   end

   // Outputs are taken straight from registers so the controller ROM sees glitch-free values.
   always_comb begin
      uOP         = uop_q;
      ZERO_FLAG   = zeroFlag_q;
      COUT_FLAG   = coutFlag_q;
      INSTR_DONE  = instrDone_q;
      INSTR_COUNT = instrCount_q;
      FAULT       = fault_q;
   end

endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: scoreboard bench for uop_sequencer. A driver applies directed and
// random stimulus on the falling edge and pushes the expected post-edge outputs from a
// behavioural model; a monitor pops and compares after every rising edge.

module tb_uop_sequencer;

   localparam int MaxUop = 6;
`ifdef UOP_SINGLE_STEP_EN
   localparam bit StepEn = 1'b1;
`else
   localparam bit StepEn = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  uop;
      logic        zero;
      logic        cout;
      logic        done;
      logic [15:0] count;
      logic        fault;
   } expect_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        RUN = 1'b0;
   logic        STEP = 1'b0;
   logic        RESET_uOP = 1'b0;
   logic        READ_FLAGS = 1'b0;
   logic        ALU_ZERO = 1'b0;
   logic        ALU_COUT = 1'b0;
   logic [2:0]  uOP;
   logic        ZERO_FLAG;
   logic        COUT_FLAG;
   logic        INSTR_DONE;
   logic [15:0] INSTR_COUNT;
   logic        FAULT;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;

   // Behavioural model: "busy" means an instruction is in flight, mPos is its micro-op position.
   bit mInit  = 1'b1;
   bit mBusy  = 1'b0;
   int mPos   = 0;
   bit mZero  = 1'b0;
   bit mCout  = 1'b0;
   bit mDone  = 1'b0;
   int mCount = 0;
   bit mFault = 1'b0;
   bit mStep  = 1'b0;

   uop_sequencer #(.MAX_UOP(MaxUop)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RUN        (RUN),
      .STEP       (STEP),
      .RESET_uOP  (RESET_uOP),
      .READ_FLAGS (READ_FLAGS),
      .ALU_ZERO   (ALU_ZERO),
      .ALU_COUT   (ALU_COUT),
      .uOP        (uOP),
      .ZERO_FLAG  (ZERO_FLAG),
      .COUT_FLAG  (COUT_FLAG),
      .INSTR_DONE (INSTR_DONE),
      .INSTR_COUNT(INSTR_COUNT),
      .FAULT      (FAULT)
   );

   always #5 CLK = ~CLK;

   // Advance the model by one rising edge with the given inputs.
   task automatic modelEdge(input bit rst, input bit run, input bit step, input bit ru,
                            input bit rf, input bit az, input bit ac);
      mDone = 1'b0;
      if (rst) begin
         mInit  = 1'b1;
         mBusy  = 1'b0;
         mPos   = 0;
         mZero  = 1'b0;
         mCout  = 1'b0;
         mCount = 0;
         mFault = 1'b0;
         mStep  = 1'b0;
      end else if (mInit) begin
         mInit = 1'b0;
         mBusy = run;
         mPos  = 0;
      end else if (!mBusy) begin
         if (run) begin
            mBusy = 1'b1;
            mPos  = 0;
         end else if (StepEn && step) begin
            mBusy = 1'b1;
            mPos  = 0;
            mStep = 1'b1;
         end
      end else begin
         if (rf) begin
            mZero = az;
            mCout = ac;
         end
         if (mPos >= 2 && ru) begin
            mDone  = 1'b1;
            mCount = (mCount + 1) % 65536;
            if (run && !mStep) mPos = 0;
            else mBusy = 1'b0;
            mStep = 1'b0;
         end else if (mPos >= MaxUop) begin
            mFault = 1'b1;
            mPos   = 0;
         end else begin
            mPos = mPos + 1;
         end
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue the expected result.
   task automatic applyStimulus(input bit rst, input bit run, input bit step, input bit ru,
                                input bit rf, input bit az, input bit ac);
      expect_t e;
      @(negedge CLK);
      RESET      = rst;
      RUN        = run;
      STEP       = step;
      RESET_uOP  = ru;
      READ_FLAGS = rf;
      ALU_ZERO   = az;
      ALU_COUT   = ac;
      modelEdge(rst, run, step, ru, rf, az, ac);
      e.uop   = mBusy ? 3'(mPos) : 3'b111;
      e.zero  = mZero;
      e.cout  = mCout;
      e.done  = mDone;
      e.count = 16'(mCount);
      e.fault = mFault;
      expQ.push_back(e);
   endtask

   // Compare every DUT output against one expected record.
   task automatic checkOutput(input expect_t e);
      checks++;
      if (uOP !== e.uop) begin
         errors++;
         $display("[TB] FAIL uOP t=%0t got %0d expected %0d", $time, uOP, e.uop);
      end
      checks++;
      if (ZERO_FLAG !== e.zero) begin
         errors++;
         $display("[TB] FAIL ZERO_FLAG t=%0t got %0b expected %0b", $time, ZERO_FLAG, e.zero);
      end
      checks++;
      if (COUT_FLAG !== e.cout) begin
         errors++;
         $display("[TB] FAIL COUT_FLAG t=%0t got %0b expected %0b", $time, COUT_FLAG, e.cout);
      end
      checks++;
      if (INSTR_DONE !== e.done) begin
         errors++;
         $display("[TB] FAIL INSTR_DONE t=%0t got %0b expected %0b", $time, INSTR_DONE, e.done);
      end
      checks++;
      if (INSTR_COUNT !== e.count) begin
         errors++;
         $display("[TB] FAIL INSTR_COUNT t=%0t got %0d expected %0d", $time, INSTR_COUNT, e.count);
      end
      checks++;
      if (FAULT !== e.fault) begin
         errors++;
         $display("[TB] FAIL FAULT t=%0t got %0b expected %0b", $time, FAULT, e.fault);
      end
   endtask

   // Monitor: sample shortly after each rising edge and score against the queue.
   initial begin
      expect_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Driver: directed scenarios first, then constrained-random traffic.
   initial begin
      bit rst, run, step, ru, rf, az, ac;

      $display("[TB] start, single-step %0s", StepEn ? "enabled" : "disabled");

      // Reset for two cycles with RUN high, then retire at uOP 3 (RESET_uOP at uOP 1 ignored).
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && !(mBusy && mPos == 3); i++)
         applyStimulus(0, 1, 0, mBusy && mPos == 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0, 0);

      // No retire: walk 0..6, overrun fault, restart at 0.
      repeat (10) applyStimulus(0, 1, 0, 0, 0, 0, 0);

      // Flag latch together with retire at uOP 4, then flags hold.
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && !(mBusy && mPos == 4); i++)
         applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 1, 1, 0);
      repeat (4) begin
         az = 1'($urandom_range(0, 1));
         ac = 1'($urandom_range(0, 1));
         applyStimulus(0, 1, 0, 0, 0, az, ac);
      end

      // RUN dropped at uOP 2, retire at uOP 4 halts into IDLE.
      for (int i = 0; i < 20 && !(mBusy && mPos == 2); i++)
         applyStimulus(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && mBusy; i++)
         applyStimulus(0, 0, 0, mPos == 4, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Single-step pulse from IDLE: one instruction then back to IDLE.
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20 && mBusy; i++)
         applyStimulus(0, 0, 0, mPos == 3, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Step pulse with RUN raised mid-instruction still returns to IDLE at retire.
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20 && mBusy; i++)
         applyStimulus(0, 1, 0, mPos == 2, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         run  = ($urandom_range(0, 9) < 7);
         step = ($urandom_range(0, 7) == 0);
         ru   = ($urandom_range(0, 2) == 0);
         rf   = 1'($urandom_range(0, 1));
         az   = 1'($urandom_range(0, 1));
         ac   = 1'($urandom_range(0, 1));
         applyStimulus(rst, run, step, ru, rf, az, ac);
      end

      @(posedge CLK);
      #5;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
